// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the issue controller: FSM encoding, scoreboard entry and source-match helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
  } sb_entry_t;

  // $0 is hardwired, so a read of it can never depend on an in-flight write.
  function automatic logic src_hit(input logic use_src, input logic [4:0] src, input sb_entry_t e);
    return use_src && e.valid && (src != REG_ZERO) && (src == e.dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter; increments on the edge after inc, holds at all-ones, clear wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage issue controller for a forwarding-less 5-stage pipe: RAW stalls and branch-shadow squash.
// Enables/bubble are combinational from decode inputs and the scoreboard; ctrl_state and counters are registered.
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int TRACK_DEPTH = 3,
  parameter int BR_SHADOW   = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_reg_wr,
  input  logic             id_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_bubble,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int SH_W = (BR_SHADOW > 1) ? $clog2(BR_SHADOW + 1) : 1;

  ctrl_state_t      state;
  sb_entry_t        sb [TRACK_DEPTH];
  logic [SH_W-1:0]  shadow;
  logic             hazard;
  logic             flushing;
  logic             stall;
  logic             issue;

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < TRACK_DEPTH; k++) begin
      if (src_hit(id_use_rs, id_rs, sb[k]) || src_hit(id_use_rt, id_rt, sb[k])) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & id_valid;
  end

  // A squashed slot neither stalls nor issues; its hazard is irrelevant.
  assign flushing    = (state == FLUSH);
  assign stall       = hazard & ~flushing;
  assign issue       = ~flushing & ~hazard;

  assign pc_en       = ~stall;
  assign ifid_en     = ~stall;
  assign idex_bubble = stall | flushing;
  assign ctrl_state  = state;

  // Entry 0 is EX; the WB entry still blocks because the regfile writes at the end of WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TRACK_DEPTH; k++) begin
        sb[k] <= '0;
      end
    end else begin
      sb[0] <= sb_entry_t'{valid: id_valid & id_reg_wr & (id_dst != REG_ZERO) & issue,
                           dst:   id_dst};
      for (int k = 1; k < TRACK_DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      shadow <= '0;
    end else begin
      case (state)
        RUN, STALL: begin
          if (hazard) begin
            state <= STALL;
          end else if (id_valid && id_br_taken && (BR_SHADOW > 0)) begin
            state  <= FLUSH;
            shadow <= SH_W'(BR_SHADOW);
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          shadow <= shadow - 1'b1;
          if (shadow == SH_W'(1)) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (stall),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (flushing),
    .clear (1'b0),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed steps then random traffic against a register-ready-time model.
module tb_pipeline_hazard_ctrl;

  localparam int TRACK  = 3;
  localparam int SHADOW = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_use_rs = 1'b0;
  logic        id_use_rt = 1'b0;
  logic [4:0]  id_dst = '0;
  logic        id_reg_wr = 1'b0;
  logic        id_br_taken = 1'b0;

  logic        pc_en, ifid_en, idex_bubble;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_en2, ifid_en2, idex_bubble2;
  logic [1:0]  ctrl_state2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_reg_wr(id_reg_wr),
    .id_br_taken(id_br_taken), .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_reg_wr(id_reg_wr),
    .id_br_taken(id_br_taken), .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_bubble(idex_bubble2),
    .ctrl_state(ctrl_state2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_until [32];
  int flush_left, stalls, flushes;
  bit stall_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_until[i] = -1;
    flush_left = 0;
    stalls     = 0;
    flushes    = 0;
    stall_prev = 0;
  endtask

  // One decode cycle: drive, check outputs against the model, then advance the model past the edge.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] dst,
                      input logic wr, input logic br);
    bit in_flush, haz;
    int exp_state;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_reg_wr = wr; id_br_taken = br;
    #1;
    in_flush  = (flush_left > 0);
    haz       = !in_flush && v &&
                ((urs && rs != 0 && busy_until[rs] >= cyc) ||
                 (urt && rt != 0 && busy_until[rt] >= cyc));
    exp_state = in_flush ? 2 : (stall_prev ? 1 : 0);
    chk("pc_en",       pc_en,        !haz);
    chk("ifid_en",     ifid_en,      !haz);
    chk("idex_bubble", idex_bubble,  haz || in_flush);
    chk("ctrl_state",  ctrl_state,   exp_state);
    chk("stall_cnt",   stall_cnt,    sat(stalls, 16));
    chk("flush_cnt",   flush_cnt,    sat(flushes, 16));
    chk("pc_en_w2",    pc_en2,       !haz);
    chk("stall_cnt_w2", stall_cnt2,  sat(stalls, 2));
    chk("flush_cnt_w2", flush_cnt2,  sat(flushes, 2));
    if (in_flush) begin
      flushes++;
      flush_left--;
      stall_prev = 0;
    end else if (haz) begin
      stalls++;
      stall_prev = 1;
    end else begin
      stall_prev = 0;
      if (v && wr && dst != 0) busy_until[dst] = cyc + TRACK;
      if (v && br) flush_left = SHADOW;
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_en"},   pc_en,       1);
    chk({tag, "_ifid_en"}, ifid_en,     1);
    chk({tag, "_bubble"},  idex_bubble, 0);
    chk({tag, "_state"},   ctrl_state,  0);
    chk({tag, "_stall"},   stall_cnt,   0);
    chk({tag, "_flush"},   flush_cnt,   0);
    chk({tag, "_stall2"},  stall_cnt2,  0);
  endtask

  initial begin
    int s0, f0;
    model_reset();
    #3;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    repeat (5) idle();
    check_reset_outputs("idle");

    // RAW on $3 one cycle behind the writer: three stall cycles, issue on the fourth.
    step(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0);
    repeat (4) step(1, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0);
    idle();
    chk("raw_stall_cnt", stall_cnt, 3);
    repeat (3) idle();

    // Writes and reads of $0 never interlock.
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0);
    step(1, 5'd0, 5'd0, 1, 1, 5'd8, 0, 0);
    chk("r0_no_stall", pc_en, 1);
    idle();
    chk("r0_stall_cnt", stall_cnt, 3);
    repeat (3) idle();

    // Taken branch; the squashed slot writes $5 and branches, and must be ignored.
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
    step(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1);
    chk("flush_state", ctrl_state, 2);
    step(1, 5'd5, 5'd0, 1, 0, 5'd9, 0, 0);
    chk("after_flush_run", ctrl_state, 0);
    idle();
    chk("br_flush_cnt", flush_cnt, 1);
    repeat (3) idle();

    // Branch reading $6 while the writer sits in MEM: two stalls, issue, one squash.
    s0 = stalls; f0 = flushes;
    step(1, 5'd0, 5'd0, 0, 0, 5'd6, 1, 0);
    step(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0);
    repeat (3) step(1, 5'd6, 5'd0, 1, 0, 5'd0, 0, 1);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    idle();
    chk("brhaz_stall_delta", stall_cnt - s0[15:0], 2);
    chk("brhaz_flush_delta", flush_cnt - f0[15:0], 1);
    repeat (3) idle();

    // Reset dropped asynchronously in the middle of a stall.
    step(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0);
    step(1, 5'd7, 5'd0, 1, 0, 5'd0, 0, 0);
    step(1, 5'd7, 5'd0, 1, 0, 5'd0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1, 5'd7, 5'd0, 1, 0, 5'd0, 0, 0);
    chk("post_rst_no_stall", pc_en, 1);

    // Five stall cycles: the 2-bit counter pins at 3.
    step(1, 5'd0, 5'd0, 0, 0, 5'd2, 1, 0);
    repeat (4) step(1, 5'd0, 5'd2, 0, 1, 5'd0, 0, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd1, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    repeat (2) step(1, 5'd1, 5'd0, 1, 0, 5'd0, 0, 0);
    idle();
    chk("sat_stall_cnt2", stall_cnt2, 3);
    chk("wide_stall_cnt", stall_cnt, 5);

    // Random traffic on a small register window to provoke frequent hazards and branches.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0);
    end
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
